// File: rtl/exe_pkg.sv
// rtl/exe_pkg.sv - shared state encoding, flag indices and default widths for the exe_unit sequencer
package exe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } exe_state_t;

  localparam int SF     = 0;
  localparam int OF     = 1;
  localparam int NF     = 2;
  localparam int BF     = 3;
  localparam int NFLAGS = 4;

  localparam int M_DEF   = 8;
  localparam int OPW_DEF = 4;

  // A single requester still needs a 1-bit pointer so port widths stay legal.
  function automatic int ptr_width(input int r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker: first set req at or above pointer, wrapping
module rr_arbiter
  import exe_pkg::*;
#(
  parameter int R = 4,
  localparam int PW = ptr_width(R)
) (
  input  logic [R-1:0]  req,
  input  logic [PW-1:0] pointer,
  output logic [R-1:0]  grant,
  output logic          any_req
);

  logic [2*R-1:0] req_dbl;
  logic [2*R-1:0] gnt_dbl;
  logic [R-1:0]   rot;
  logic [R-1:0]   oh;

  // Rotate so the pointer sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    req_dbl = {req, req} >> pointer;
    rot     = req_dbl[R-1:0];
    oh      = rot & (~rot + R'(1));
    gnt_dbl = {{R{1'b0}}, oh} << pointer;
    grant   = gnt_dbl[R-1:0] | gnt_dbl[2*R-1:R];
  end

  assign any_req = |req;

endmodule

// File: rtl/exe_unit_arbiter.sv
// rtl/exe_unit_arbiter.sv - round-robin sequencer sharing one combinational exe_unit among R requesters
module exe_unit_arbiter
  import exe_pkg::*;
#(
  parameter int R   = 4,
  parameter int M   = M_DEF,
  parameter int OPW = OPW_DEF
) (
  input  logic              i_sclk,
  input  logic              i_rst,
  input  logic [R-1:0]      i_req,
  input  logic [R*M-1:0]    i_argA,
  input  logic [R*M-1:0]    i_argB,
  input  logic [R*OPW-1:0]  i_oper,
  output logic [R-1:0]      o_ack,
  output logic [R-1:0]      o_done,
  output logic [M-1:0]      o_result,
  output logic [NFLAGS-1:0] o_flags,
  output logic              o_busy,
  output logic [M-1:0]      o_exe_argA,
  output logic [M-1:0]      o_exe_argB,
  output logic [OPW-1:0]    o_exe_oper,
  input  logic [M-1:0]      i_exe_result,
  input  logic [NFLAGS-1:0] i_exe_flags
);

  localparam int PW = ptr_width(R);

  exe_state_t        state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [R-1:0]      owner_q, owner_d;
  logic [R-1:0]      ack_q, ack_d;
  logic [R-1:0]      done_q, done_d;
  logic [M-1:0]      result_q, result_d;
  logic [NFLAGS-1:0] flags_q, flags_d;
  logic [M-1:0]      arg_a_q, arg_a_d;
  logic [M-1:0]      arg_b_q, arg_b_d;
  logic [OPW-1:0]    oper_q, oper_d;

  logic [R-1:0]      grant;
  logic              any_req;
  logic [PW-1:0]     gnt_idx;

  rr_arbiter #(.R(R)) u_rr (
    .req     (i_req),
    .pointer (ptr_q),
    .grant   (grant),
    .any_req (any_req)
  );

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < R; i++) begin
      if (grant[i]) gnt_idx = PW'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    ack_d    = '0;
    done_d   = '0;
    result_d = result_q;
    flags_d  = flags_q;
    arg_a_d  = arg_a_q;
    arg_b_d  = arg_b_q;
    oper_d   = oper_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = EXEC;
          owner_d = grant;
          ack_d   = grant;
          ptr_d   = (gnt_idx == PW'(R - 1)) ? '0 : gnt_idx + PW'(1);
          for (int i = 0; i < R; i++) begin
            if (grant[i]) begin
              arg_a_d = i_argA[i*M +: M];
              arg_b_d = i_argB[i*M +: M];
              oper_d  = i_oper[i*OPW +: OPW];
            end
          end
        end
      end
      // The exe_unit has had the whole EXEC cycle to settle on the latched operands.
      EXEC: begin
        result_d = i_exe_result;
        flags_d  = i_exe_flags;
        done_d   = owner_q;
        state_d  = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_sclk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      ack_q    <= '0;
      done_q   <= '0;
      result_q <= '0;
      flags_q  <= '0;
      arg_a_q  <= '0;
      arg_b_q  <= '0;
      oper_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      arg_a_q  <= arg_a_d;
      arg_b_q  <= arg_b_d;
      oper_q   <= oper_d;
    end
  end

  assign o_ack      = ack_q;
  assign o_done     = done_q;
  assign o_result   = result_q;
  assign o_flags    = flags_q;
  assign o_busy     = (state_q == EXEC) || (state_q == DONE);
  assign o_exe_argA = arg_a_q;
  assign o_exe_argB = arg_b_q;
  assign o_exe_oper = oper_q;

endmodule

// File: tb/tb_exe_unit_arbiter.sv
// tb/tb_exe_unit_arbiter.sv - scoreboard bench for exe_unit_arbiter (R=4 and R=1 builds)
module tb_exe_unit_arbiter;

  localparam int R   = 4;
  localparam int M   = 8;
  localparam int OPW = 4;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;

  // Golden exe_unit: returns {BF,NF,OF,SF, result}; SF is the zero flag here.
  function automatic logic [11:0] golden(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    logic [8:0] w;
    logic       ovf;
    ovf = 1'b0;
    case (op)
      OP_ADD: begin w = {1'b0, a} + {1'b0, b}; ovf = (a[7] == b[7]) && (w[7] != a[7]); end
      OP_SUB: begin w = {1'b0, a} - {1'b0, b}; ovf = (a[7] != b[7]) && (w[7] != a[7]); end
      OP_AND: w = {1'b0, a & b};
      OP_OR:  w = {1'b0, a | b};
      OP_XOR: w = {1'b0, a ^ b};
      default: w = {1'b0, a};
    endcase
    return {w[8], w[7], ovf, (w[7:0] == 8'h00), w[7:0]};
  endfunction

  function automatic logic get_b(input logic [R-1:0] v, input int k);
    logic [R-1:0] t;
    t = v >> k;
    return t[0];
  endfunction

  function automatic logic [M-1:0] get_m(input logic [R*M-1:0] v, input int k);
    logic [R*M-1:0] t;
    t = v >> (k * M);
    return t[M-1:0];
  endfunction

  function automatic logic [R*M-1:0] put_m(input logic [R*M-1:0] v, input int k, input logic [M-1:0] x);
    logic [R*M-1:0] msk;
    msk = {{(R*M-M){1'b0}}, {M{1'b1}}} << (k * M);
    return (v & ~msk) | ({{(R*M-M){1'b0}}, x} << (k * M));
  endfunction

  function automatic logic [OPW-1:0] get_o(input logic [R*OPW-1:0] v, input int k);
    logic [R*OPW-1:0] t;
    t = v >> (k * OPW);
    return t[OPW-1:0];
  endfunction

  function automatic logic [R*OPW-1:0] put_o(input logic [R*OPW-1:0] v, input int k, input logic [OPW-1:0] x);
    logic [R*OPW-1:0] msk;
    msk = {{(R*OPW-OPW){1'b0}}, {OPW{1'b1}}} << (k * OPW);
    return (v & ~msk) | ({{(R*OPW-OPW){1'b0}}, x} << (k * OPW));
  endfunction

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [R-1:0]     req;
  logic [R*M-1:0]   arg_a, arg_b;
  logic [R*OPW-1:0] oper;
  logic [R-1:0]     ack, done;
  logic [M-1:0]     result;
  logic [3:0]       flags;
  logic             busy;
  logic [M-1:0]     exe_a, exe_b, exe_res;
  logic [OPW-1:0]   exe_op;
  logic [3:0]       exe_flg;

  logic             req1;
  logic [M-1:0]     a1, b1;
  logic [OPW-1:0]   op1;
  logic [0:0]       ack1, done1;
  logic [M-1:0]     result1;
  logic [3:0]       flags1;
  logic             busy1;
  logic [M-1:0]     exe1_a, exe1_b, exe1_res;
  logic [OPW-1:0]   exe1_op;
  logic [3:0]       exe1_flg;

  assign {exe_flg, exe_res}   = golden(exe_a, exe_b, exe_op);
  assign {exe1_flg, exe1_res} = golden(exe1_a, exe1_b, exe1_op);

  exe_unit_arbiter #(.R(R), .M(M), .OPW(OPW)) u_dut (
    .i_sclk(clk), .i_rst(rst_n), .i_req(req),
    .i_argA(arg_a), .i_argB(arg_b), .i_oper(oper),
    .o_ack(ack), .o_done(done), .o_result(result), .o_flags(flags), .o_busy(busy),
    .o_exe_argA(exe_a), .o_exe_argB(exe_b), .o_exe_oper(exe_op),
    .i_exe_result(exe_res), .i_exe_flags(exe_flg)
  );

  exe_unit_arbiter #(.R(1), .M(M), .OPW(OPW)) u_dut1 (
    .i_sclk(clk), .i_rst(rst_n), .i_req(req1),
    .i_argA(a1), .i_argB(b1), .i_oper(op1),
    .o_ack(ack1), .o_done(done1), .o_result(result1), .o_flags(flags1), .o_busy(busy1),
    .o_exe_argA(exe1_a), .o_exe_argB(exe1_b), .o_exe_oper(exe1_op),
    .i_exe_result(exe1_res), .i_exe_flags(exe1_flg)
  );

  typedef struct {
    int           cyc;
    logic [R-1:0] vec;
    logic [19:0]  val;
  } exp_t;

  exp_t ack_q[$], done_q[$], ack1_q[$], done1_q[$];

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: a free arbiter grants the first pending requester from the
  // rotating pointer; it is next free three edges later.
  int           m_ptr = 0, m_free = 0, m1_free = 0, m_w;
  logic [R-1:0] drop_mask = '0;
  logic         drop1 = 1'b0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    drop_mask = '0;
    drop1 = 1'b0;
    if (!rst_n) begin
      m_ptr = 0; m_free = 0; m1_free = 0;
      ack_q.delete(); done_q.delete(); ack1_q.delete(); done1_q.delete();
    end else begin
      if (cyc >= m_free && req != '0) begin
        m_w = -1;
        for (int i = 0; i < R; i++) begin
          int k;
          k = (m_ptr + i) % R;
          if (m_w < 0 && get_b(req, k)) m_w = k;
        end
        ack_q.push_back('{cyc, R'(1) << m_w,
                          {get_o(oper, m_w), get_m(arg_a, m_w), get_m(arg_b, m_w)}});
        done_q.push_back('{cyc + 1, R'(1) << m_w,
                           20'(golden(get_m(arg_a, m_w), get_m(arg_b, m_w), get_o(oper, m_w)))});
        m_ptr = (m_w + 1) % R;
        m_free = cyc + 3;
        drop_mask = R'(1) << m_w;
      end
      if (cyc >= m1_free && req1) begin
        ack1_q.push_back('{cyc, R'(1), {op1, a1, b1}});
        done1_q.push_back('{cyc + 1, R'(1), 20'(golden(a1, b1, op1))});
        m1_free = cyc + 3;
        drop1 = 1'b1;
      end
    end
  end

  // Monitor: every cycle, the expected pulse is whatever the scoreboard holds for this cycle.
  always @(negedge clk) begin
    exp_t         e;
    logic [R-1:0] xv;
    xv = '0;
    if (ack_q.size() > 0 && ack_q[0].cyc == cyc) begin
      e = ack_q.pop_front(); xv = e.vec;
      chk("exe_args", {exe_op, exe_a, exe_b}, e.val);
    end
    chk("ack", ack, xv);
    xv = '0;
    if (done_q.size() > 0 && done_q[0].cyc == cyc) begin
      e = done_q.pop_front(); xv = e.vec;
      chk("result_flags", {flags, result}, e.val);
    end
    chk("done", done, xv);
    chk("busy", busy, cyc < m_free - 1);

    xv = '0;
    if (ack1_q.size() > 0 && ack1_q[0].cyc == cyc) begin
      e = ack1_q.pop_front(); xv = e.vec;
      chk("r1_exe_args", {exe1_op, exe1_a, exe1_b}, e.val);
    end
    chk("r1_ack", ack1, xv[0]);
    xv = '0;
    if (done1_q.size() > 0 && done1_q[0].cyc == cyc) begin
      e = done1_q.pop_front(); xv = e.vec;
      chk("r1_result_flags", {flags1, result1}, e.val);
    end
    chk("r1_done", done1, xv[0]);
    chk("r1_busy", busy1, cyc < m1_free - 1);
  end

  logic [R-1:0] cont = '0;
  int           ops1_left = 0;

  // One cycle of requester behaviour: granted requesters drop req (unless
  // re-requesting continuously) and scramble their operands, which must not matter.
  task automatic step();
    @(negedge clk);
    for (int k = 0; k < R; k++) begin
      if (get_b(drop_mask, k)) begin
        arg_a = put_m(arg_a, k, M'($urandom));
        arg_b = put_m(arg_b, k, M'($urandom));
        oper  = put_o(oper, k, OPW'($urandom_range(0, 7)));
        if (!get_b(cont, k)) req = req & ~(R'(1) << k);
      end
    end
    if (drop1) begin
      a1 = M'($urandom); b1 = M'($urandom); op1 = OPW'($urandom_range(0, 7));
      if (ops1_left <= 1) begin ops1_left = 0; req1 = 1'b0; end
      else ops1_left--;
    end
  endtask

  task automatic raise(input int k, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    arg_a = put_m(arg_a, k, a);
    arg_b = put_m(arg_b, k, b);
    oper  = put_o(oper, k, op);
    req   = req | (R'(1) << k);
  endtask

  task automatic raise_rand(input int k);
    raise(k, M'($urandom), M'($urandom), OPW'($urandom_range(0, 7)));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_flags"}, flags, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_exe"}, {exe_op, exe_a, exe_b}, 0);
    chk({tag, "_r1"}, {ack1, done1, busy1, flags1, result1}, 0);
  endtask

  initial begin
    req = '0; arg_a = '0; arg_b = '0; oper = '0;
    req1 = 1'b0; a1 = '0; b1 = '0; op1 = '0;
    repeat (3) step();
    chk_zero("reset");
    rst_n = 1'b1;
    step();

    // pointer 0, requesters 1 and 3 together: 1 first, 3 at the next IDLE
    raise(1, 8'hFF, 8'h01, OP_ADD);
    raise(3, 8'h00, 8'h01, OP_SUB);
    repeat (8) step();

    raise(2, 8'h05, 8'h03, OP_ADD);
    repeat (5) step();

    // requester 0 back to back, five grants
    cont = 4'b0001;
    raise_rand(0);
    repeat (12) step();
    cont = '0;
    repeat (6) step();

    // everyone continuously requesting
    cont = '1;
    for (int k = 0; k < R; k++) raise_rand(k);
    repeat (35) step();
    cont = '0;
    repeat (14) step();

    repeat (300) begin
      step();
      for (int k = 0; k < R; k++)
        if (!get_b(req, k) && $urandom_range(0, 3) == 0) raise_rand(k);
    end
    repeat (14) step();

    // reset while in EXEC: no done, everything zero at once
    raise_rand(1);
    step();
    #2;
    rst_n = 1'b0;
    req = '0;
    #1;
    chk_zero("rst_exec");
    repeat (2) step();
    rst_n = 1'b1;
    raise_rand(1);
    raise_rand(2);
    repeat (8) step();

    // single-requester build: three operations in a row
    ops1_left = 3;
    req1 = 1'b1;
    a1 = M'($urandom); b1 = M'($urandom); op1 = OP_ADD;
    repeat (12) step();
    repeat (2) step();

    chk("pending_ack", ack_q.size() + ack1_q.size(), 0);
    chk("pending_done", done_q.size() + done1_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
